irq_controller: RTL and testbench

//  Core-side responder for the int_req interrupt lines driven by peripherals/bench.

---
 rtl/irq_controller_if.sv | 24 ++
 rtl/irq_controller.sv | 133 +++++++++++++
 tb/tb_irq_controller.sv | 249 ++++++++++++++++++++++++
 3 files changed

// File: rtl/irq_controller_if.sv
// Bus between the peripheral request lines, the CSR enables and the core trap
// logic. The controller takes the slave view. The core or bench takes the master view.
interface irq_controller_if #(
   parameter int N_IRQ = 32
);
   logic [N_IRQ-1:0] irq_req_i;    // request lines (level, or rising edge when edge mode is built)
   logic [N_IRQ-1:0] mie_i;        // per-line enable from mie CSR
   logic             gie_i;        // global enable (mstatus.MIE)
   logic             mret_i;       // core executing mret this cycle
   logic             irq_o;        // one-cycle trap request
   logic [31:0]      irq_cause_o;  // mcause of the accepted line, held until return
   logic [N_IRQ-1:0] irq_ret_o;    // one-hot completion to the served requester
   logic             busy_o;       // an interrupt is being issued or serviced

   modport master (
      output irq_req_i, mie_i, gie_i, mret_i,
      input  irq_o, irq_cause_o, irq_ret_o, busy_o
   );

   modport slave (
      input  irq_req_i, mie_i, gie_i, mret_i,
      output irq_o, irq_cause_o, irq_ret_o, busy_o
   );
endinterface

// File: rtl/irq_controller.sv
// Fixed-priority, non-nesting interrupt responder.
// Masks the request lines and picks the lowest active index. It issues a
// one-cycle trap request carrying mcause, then waits for mret and returns a
// one-hot completion to the line it served.
// Optional feature: define IRQ_EDGE_EN to capture rising edges of the request
// lines into per-line pending flags. Without it the request lines are
// level-sensitive.
module irq_controller #(
   parameter int          N_IRQ     = 32,
   parameter logic [31:0] CAUSE_OFS = 32'h8000_0010
) (
   input logic             clk_i,
   input logic             rst_i,
   irq_controller_if.slave bus
);

   localparam int IDX_W = (N_IRQ > 1) ? $clog2(N_IRQ) : 1;

   typedef enum logic [1:0] {
      IDLE    = 2'd0,
      ISSUE   = 2'd1,
      SERVICE = 2'd2
   } state_e;

   state_e             state_q, state_d;
   logic [IDX_W-1:0]   idx_q, idx_d;
   logic [31:0]        cause_q, cause_d;

   logic [N_IRQ-1:0]   src;
   logic [N_IRQ-1:0]   act;
   logic [IDX_W-1:0]   sel_idx;
   logic               any_act;
   logic [N_IRQ-1:0]   ret_vec;

`ifdef IRQ_EDGE_EN
   logic [N_IRQ-1:0]   pend_q, pend_d;
   logic [N_IRQ-1:0]   prev_q, prev_d;

   // Pending flags: a rising edge sets the flag. The served line is cleared on
   // its mret edge, and a new edge on the same cycle takes precedence.
   always_comb begin
      prev_d = bus.irq_req_i;
      pend_d = (pend_q & ~ret_vec) | (bus.irq_req_i & ~prev_q);
   end

   // Pending and previous-value registers.
   always_ff @(posedge clk_i or posedge rst_i) begin
      if (rst_i) begin
         pend_q <= '0;
         prev_q <= '0;
      end else begin
         pend_q <= pend_d;
         prev_q <= prev_d;
      end
   end

   assign src = pend_q;
`else
   assign src = bus.irq_req_i;
`endif

   assign act     = src & bus.mie_i & {N_IRQ{bus.gie_i}};
   assign any_act = |act;

   // Priority encoder: lowest set index of act wins.
   always_comb begin
      // NOTE: combinational blocks use blocking '=' so later statements see the
      // updated value. Here, scanning downward lets the lowest index overwrite.
      sel_idx = '0;
      for (int i = N_IRQ - 1; i >= 0; i--) begin
         if (act[i]) sel_idx = IDX_W'(i);
      end
   end

   // State register plus the latched index and cause.
   always_ff @(posedge clk_i or posedge rst_i) begin
      // NOTE: clocked state uses non-blocking '<=' so every flop samples
      // pre-edge values, independent of statement order.
      if (rst_i) begin
         state_q <= IDLE;
         idx_q   <= '0;
         cause_q <= '0;
      end else begin
         state_q <= state_d;
         idx_q   <= idx_d;
         cause_q <= cause_d;
      end
   end

   // Next-state logic. New requests are accepted only in IDLE.
   always_comb begin
      // NOTE: every variable gets a default first, so no path leaves it
      // unassigned and no latch is inferred.
      state_d = state_q;
      idx_d   = idx_q;
      cause_d = cause_q;
      unique case (state_q)
         IDLE: begin
            if (any_act) begin
               idx_d   = sel_idx;
               cause_d = CAUSE_OFS + 32'(sel_idx);
               state_d = ISSUE;
            end
         end
         ISSUE: begin
            state_d = SERVICE;
         end
         SERVICE: begin
            if (bus.mret_i) begin
               cause_d = '0;
               state_d = IDLE;
            end
         end
         default: begin
            state_d = IDLE;
         end
      endcase
   end

   // Outputs: the trap pulse in ISSUE, and the completion while mret is seen in SERVICE.
   always_comb begin
      ret_vec = '0;
      if (state_q == SERVICE && bus.mret_i) begin
         ret_vec = N_IRQ'(1) << idx_q;
      end
   end

   assign bus.irq_o       = (state_q == ISSUE);
   assign bus.irq_cause_o = cause_q;
   assign bus.irq_ret_o   = ret_vec;
   assign bus.busy_o      = (state_q != IDLE);

endmodule

// File: tb/tb_irq_controller.sv
// Directed bench for irq_controller. Expected causes and completions are
// queued when a request is driven, then popped when the DUT answers.
module tb_irq_controller;

   localparam int N_IRQ = 32;
`ifdef IRQ_EDGE_EN
   localparam int ACCEPT_LAT = 2;  // edge captured, then accepted one edge later
`else
   localparam int ACCEPT_LAT = 1;
`endif

   logic clk = 1'b0;
   logic rst;
   always #5 clk = ~clk;

   irq_controller_if #(.N_IRQ(N_IRQ)) bus ();

   irq_controller #(
      .N_IRQ    (N_IRQ),
      .CAUSE_OFS(32'h8000_0010)
   ) dut (
      .clk_i(clk),
      .rst_i(rst),
      .bus  (bus)
   );

   int vectors     = 0;
   int miscompares = 0;
   logic [31:0] exp_cause_q[$];
   logic [31:0] exp_ret_q[$];

   task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      vectors++;
      assert (obs === exp)
      else begin
         miscompares++;
         $error("FAIL %s: observed %h expected %h", tag, obs, exp);
      end
   endtask

   task automatic cyc();
      @(posedge clk);
      #1;
   endtask

   task automatic sb_pop(input string tag, inout logic [31:0] q[$], input logic [31:0] obs);
      if (q.size() == 0) begin
         vectors++;
         miscompares++;
         $error("FAIL %s: observed %h expected nothing (scoreboard empty)", tag, obs);
      end else begin
         check(tag, obs, q.pop_front());
      end
   endtask

   // Wait (bounded) for the trap pulse, check cause, then check the pulse is one cycle.
   task automatic wait_issue(input string tag, output int lat);
      logic [31:0] cause_seen;
      lat = 0;
      while (bus.irq_o !== 1'b1 && lat < 10) begin
         cyc();
         lat++;
      end
      check({tag, "_irq"}, 32'(bus.irq_o), 32'd1);
      cause_seen = bus.irq_cause_o;
      sb_pop({tag, "_cause"}, exp_cause_q, cause_seen);
      check({tag, "_busy"}, 32'(bus.busy_o), 32'd1);
      cyc();
      check({tag, "_pulse_end"}, 32'(bus.irq_o), 32'd0);
      check({tag, "_cause_held"}, bus.irq_cause_o, cause_seen);
   endtask

   // Assert mret for one cycle, compare the completion, then drop the served line.
   task automatic finish_service(input string tag, input logic [31:0] drop);
      bus.mret_i = 1'b1;
      #1;
      sb_pop({tag, "_ret"}, exp_ret_q, bus.irq_ret_o);
      @(posedge clk);
      #1;
      bus.mret_i    = 1'b0;
      bus.irq_req_i = bus.irq_req_i & ~drop;
      check({tag, "_idle_busy"}, 32'(bus.busy_o), 32'd0);
      check({tag, "_idle_cause"}, bus.irq_cause_o, 32'd0);
      check({tag, "_idle_ret"}, bus.irq_ret_o, 32'd0);
   endtask

   // Hold for n cycles and report whether any trap pulse appeared.
   task automatic quiet(input string tag, input int n);
      logic seen;
      seen = 1'b0;
      repeat (n) begin
         cyc();
         if (bus.irq_o === 1'b1) seen = 1'b1;
      end
      check(tag, 32'(seen), 32'd0);
   endtask

   initial begin
      #100000;
      $display("FAIL watchdog: time limit reached");
      $fatal(1, "watchdog");
   end

   initial begin
      int lat;

      // Reset
      rst           = 1'b1;
      bus.irq_req_i = '0;
      bus.mie_i     = '0;
      bus.gie_i     = 1'b0;
      bus.mret_i    = 1'b0;
      cyc();
      cyc();
      rst = 1'b0;
      cyc();
      check("rst_irq", 32'(bus.irq_o), 32'd0);
      check("rst_cause", bus.irq_cause_o, 32'd0);
      check("rst_ret", bus.irq_ret_o, 32'd0);
      check("rst_busy", 32'(bus.busy_o), 32'd0);

      // Single request on line 0
      bus.mie_i = 32'h1;
      bus.gie_i = 1'b1;
      exp_cause_q.push_back(32'h8000_0010);
      exp_ret_q.push_back(32'h1);
      bus.irq_req_i = 32'h1;
      #1;
      check("t2_no_comb_irq", 32'(bus.irq_o), 32'd0);
      wait_issue("t2", lat);
      check("t2_latency", 32'(lat), 32'(ACCEPT_LAT));
      finish_service("t2", 32'h1);
      quiet("t2_no_refire", 3);

      // Two simultaneous requests: line 2 first, then line 4
      bus.mie_i = '1;
      exp_cause_q.push_back(32'h8000_0012);
      exp_ret_q.push_back(32'h4);
      exp_cause_q.push_back(32'h8000_0014);
      exp_ret_q.push_back(32'h10);
      bus.irq_req_i = 32'h0000_0014;
      wait_issue("t3a", lat);
      finish_service("t3a", 32'h4);
      wait_issue("t3b", lat);
      finish_service("t3b", 32'h10);
      quiet("t3_quiet", 3);

      // mret during ISSUE is ignored; highest line index
      exp_cause_q.push_back(32'h8000_002F);
      bus.irq_req_i = 32'h8000_0000;
      lat = 0;
      while (bus.irq_o !== 1'b1 && lat < 10) begin
         cyc();
         lat++;
      end
      check("t7_irq", 32'(bus.irq_o), 32'd1);
      sb_pop("t7_cause", exp_cause_q, bus.irq_cause_o);
      bus.mret_i = 1'b1;
      #1;
      check("t7_ret_in_issue", bus.irq_ret_o, 32'd0);
      cyc();
      check("t7_busy_service", 32'(bus.busy_o), 32'd1);
      exp_ret_q.push_back(32'h8000_0000);
      sb_pop("t7_ret", exp_ret_q, bus.irq_ret_o);
      @(posedge clk);
      #1;
      bus.mret_i    = 1'b0;
      bus.irq_req_i = '0;
      check("t7_idle", 32'(bus.busy_o), 32'd0);

      // Request dropped during SERVICE still completes
      exp_cause_q.push_back(32'h8000_0018);
      exp_ret_q.push_back(32'h100);
      bus.irq_req_i = 32'h100;
      wait_issue("t8", lat);
      bus.irq_req_i = '0;
      cyc();
      check("t8_busy_after_drop", 32'(bus.busy_o), 32'd1);
      finish_service("t8", 32'h0);

      // Masked by mie, then by gie; mret in IDLE gives no completion
      bus.irq_req_i = 32'h1;
      bus.mie_i     = '0;
      bus.gie_i     = 1'b1;
      quiet("t4_mie_masked", 20);
      bus.mret_i = 1'b1;
      #1;
      check("t4_ret_idle", bus.irq_ret_o, 32'd0);
      cyc();
      bus.mret_i = 1'b0;
      check("t4_busy", 32'(bus.busy_o), 32'd0);
      bus.mie_i = '1;
      bus.gie_i = 1'b0;
      quiet("t4_gie_masked", 20);
      rst           = 1'b1;  // also clears any pending flag captured while masked
      bus.irq_req_i = '0;
      bus.gie_i     = 1'b1;
      cyc();
      rst = 1'b0;
      cyc();

      // Asynchronous reset in SERVICE aborts without a completion
      exp_cause_q.push_back(32'h8000_0011);
      bus.irq_req_i = 32'h2;
      wait_issue("t5", lat);
      #2;
      rst = 1'b1;
      #1;
      check("t5_busy", 32'(bus.busy_o), 32'd0);
      check("t5_cause", bus.irq_cause_o, 32'd0);
      check("t5_irq", 32'(bus.irq_o), 32'd0);
      bus.irq_req_i = '0;
      @(negedge clk);
      rst = 1'b0;
      cyc();
      bus.mret_i = 1'b1;
      #1;
      check("t5_ret_after_abort", bus.irq_ret_o, 32'd0);
      cyc();
      bus.mret_i = 1'b0;
      check("t5_idle", 32'(bus.busy_o), 32'd0);

`ifdef IRQ_EDGE_EN
      // One-cycle pulse is captured; a held level fires only once
      exp_cause_q.push_back(32'h8000_0013);
      exp_ret_q.push_back(32'h8);
      bus.irq_req_i = 32'h8;
      cyc();
      bus.irq_req_i = '0;
      wait_issue("t6_pulse", lat);
      finish_service("t6_pulse", 32'h0);
      exp_cause_q.push_back(32'h8000_0013);
      exp_ret_q.push_back(32'h8);
      bus.irq_req_i = 32'h8;
      wait_issue("t6_level", lat);
      finish_service("t6_level", 32'h0);
      quiet("t6_no_second_irq", 20);
      bus.irq_req_i = '0;
      cyc();
`endif

      check("sb_cause_drained", 32'(exp_cause_q.size()), 32'd0);
      check("sb_ret_drained", 32'(exp_ret_q.size()), 32'd0);

      $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
      $finish;
   end

endmodule
